sprite_fetch_unit: RTL and testbench

- Upstream address generator and pixel-alignment stage for the character sprite ROMs (12-bit RGB444, synchronous 1-cycle read).
- Takes the current VGA scan coordinate and the sprite placement, and drives the ROM address.
- Realigns the returned ROM word with a 3-stage pipeline and applies the transparency key.
- Produces a per-pixel sprite colour and a coverage flag for the downstream colour mux.

---
 rtl/sprite_fetch_unit.sv | 111 +++++++++++
 tb/tb_sprite_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_unit.sv
// Sprite fetch and pixel-alignment stage.
// Turns the current scan coordinate and a per-frame sprite placement into a
// sprite ROM address, then realigns the returned ROM word so that colour and
// coverage appear exactly three cycles after the coordinate was presented.
module sprite_fetch_unit #(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    SPR_W      = 20,
    parameter int                    SPR_H      = 11,
    parameter int                    COORD_W    = 10,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'h0F0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [COORD_W-1:0]    pixel_x,
    input  logic [COORD_W-1:0]    pixel_y,
    input  logic [COORD_W-1:0]    pos_x,
    input  logic [COORD_W-1:0]    pos_y,
    input  logic                  mirror,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] sprite_rgb,
    output logic                  sprite_on
);

    // Sprite dimensions widened to the one-bit-extended coordinate width so
    // every comparison below is unsigned and carries no wrap-around.
    localparam logic [COORD_W:0] SPR_W_C = (COORD_W+1)'(SPR_W);
    localparam logic [COORD_W:0] SPR_H_C = (COORD_W+1)'(SPR_H);

    // Placement shadow registers, only updated at frame start.
    logic [COORD_W-1:0]    x0_q, y0_q;
    logic                  mir_q;

    // Pipeline registers.
    logic                  hit1_q, hit2_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [DATA_WIDTH-1:0] sprite_rgb_q;
    logic                  sprite_on_q;

    // Stage-1 combinational results.
    logic [COORD_W:0]      dx, dy, col;
    logic                  hit1_d;
    logic [ADDR_WIDTH-1:0] rom_addr_d;
    logic                  opaque_d;

    // Latch the requested placement once per frame so a frame never tears.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge value of its sources, independent of block ordering.
        if (reset) begin
            x0_q  <= '0;
            y0_q  <= '0;
            mir_q <= 1'b0;
        end else if (frame_start) begin
            x0_q  <= pos_x;
            y0_q  <= pos_y;
            mir_q <= mirror;
        end
    end

    // Hit test and ROM address for the coordinate presented this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        dx         = {1'b0, pixel_x} - {1'b0, x0_q};
        dy         = {1'b0, pixel_y} - {1'b0, y0_q};
        col        = dx;
        hit1_d     = 1'b0;
        rom_addr_d = '0;
        if ((pixel_x >= x0_q) && (dx < SPR_W_C) &&
            (pixel_y >= y0_q) && (dy < SPR_H_C)) begin
            hit1_d = 1'b1;
        end
        if (mir_q) begin
            col = (SPR_W_C - 1'b1) - dx;
        end
        if (hit1_d) begin
            // Both operands are in range on a hit, so ADDR_WIDTH modular
            // arithmetic gives the exact row-major word index.
            rom_addr_d = ADDR_WIDTH'(dy) * ADDR_WIDTH'(SPR_W) + ADDR_WIDTH'(col);
        end
    end

    // Transparency test on the ROM word belonging to the stage-2 pixel.
    always_comb begin
        opaque_d = hit2_q && (rom_data != KEY_COLOR);
    end

    // Three-stage pipeline: address, ROM access, colour/coverage.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit1_q       <= 1'b0;
            hit2_q       <= 1'b0;
            rom_addr_q   <= '0;
            sprite_rgb_q <= '0;
            sprite_on_q  <= 1'b0;
        end else begin
            hit1_q       <= hit1_d;
            rom_addr_q   <= rom_addr_d;
            hit2_q       <= hit1_q;
            sprite_on_q  <= opaque_d;
            sprite_rgb_q <= opaque_d ? rom_data : '0;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign sprite_rgb = sprite_rgb_q;
    assign sprite_on  = sprite_on_q;

endmodule

// File: tb/tb_sprite_fetch_unit.sv
// Bench for sprite_fetch_unit: a behavioural ROM plus a reference model that
// derives each pixel's expected address/colour/coverage from the placement
// rules directly, then compares them at the documented latencies.
module tb_sprite_fetch_unit;

    localparam logic [11:0] KEY = 12'h0F0;

    typedef struct {
        logic [7:0]  addr;
        logic        on;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, frame_start, mirror;
    logic [9:0]  pixel_x, pixel_y, pos_x, pos_y;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic [11:0] sprite_rgb;
    logic        sprite_on;

    logic [11:0] rom [0:255];
    exp_t        hist [0:4095];
    int          n;
    int          m_x0, m_y0;
    bit          m_mir;
    int          checks = 0;
    int          errors = 0;

    sprite_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .mirror     (mirror),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sprite_rgb (sprite_rgb),
        .sprite_on  (sprite_on)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result for one coordinate under the current placement.
    function automatic exp_t model(input logic [9:0] px, input logic [9:0] py);
        exp_t r;
        int dx, dy, col;
        dx = int'(px) - m_x0;
        dy = int'(py) - m_y0;
        r.addr = '0;
        r.on   = 1'b0;
        r.rgb  = '0;
        if (dx >= 0 && dx < 20 && dy >= 0 && dy < 11) begin
            col    = m_mir ? (19 - dx) : dx;
            r.addr = 8'(dy * 20 + col);
            if (rom[r.addr] != KEY) begin
                r.on  = 1'b1;
                r.rgb = rom[r.addr];
            end
        end
        return r;
    endfunction

    // One clock cycle: drive inputs, record expectations, check after edge.
    task automatic cyc(input logic rst, input logic fs,
                       input logic [9:0] px, input logic [9:0] py,
                       input logic [9:0] psx, input logic [9:0] psy,
                       input logic mr);
        reset       = rst;
        frame_start = fs;
        pixel_x     = px;
        pixel_y     = py;
        pos_x       = psx;
        pos_y       = psy;
        mirror      = mr;
        hist[n] = model(px, py);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                hist[n-k].addr = '0;
                hist[n-k].on   = 1'b0;
                hist[n-k].rgb  = '0;
            end
            m_x0  = 0;
            m_y0  = 0;
            m_mir = 1'b0;
        end else if (fs) begin
            m_x0  = int'(psx);
            m_y0  = int'(psy);
            m_mir = mr;
        end
        @(posedge clk);
        #1;
        check("model_rom_addr",   32'(rom_addr),   32'(hist[n].addr));
        check("model_sprite_on",  32'(sprite_on),  32'(hist[n-2].on));
        check("model_sprite_rgb", 32'(sprite_rgb), 32'(hist[n-2].rgb));
        n++;
    endtask

    initial begin
        bit         r_fs, r_rst;
        logic [9:0] r_px, r_py;

        for (int i = 0; i < 256; i++) begin
            rom[i] = 12'($urandom_range(0, 4095));
            if (rom[i] == KEY) rom[i] = 12'h123;
        end
        rom[5] = KEY;
        for (int i = 0; i < 4096; i++) begin
            hist[i].addr = '0;
            hist[i].on   = 1'b0;
            hist[i].rgb  = '0;
        end
        n = 2;
        m_x0 = 0; m_y0 = 0; m_mir = 1'b0;

        // Reset state.
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        check("reset_rom_addr",   32'(rom_addr),   32'd0);
        check("reset_sprite_on",  32'(sprite_on),  32'd0);
        check("reset_sprite_rgb", 32'(sprite_rgb), 32'd0);

        // Basic placement, corner addresses and latency.
        cyc(0, 1, 0, 0, 100, 50, 0);
        cyc(0, 0, 100, 50, 0, 0, 0);
        check("addr_top_left", 32'(rom_addr), 32'd0);
        cyc(0, 0, 119, 60, 0, 0, 0);
        check("addr_bottom_right", 32'(rom_addr), 32'd219);
        cyc(0, 0, 120, 50, 0, 0, 0);
        check("lat3_sprite_on",  32'(sprite_on),  32'd1);
        check("lat3_sprite_rgb", 32'(sprite_rgb), 32'(rom[0]));
        check("miss_right_addr", 32'(rom_addr),   32'd0);
        cyc(0, 0, 99, 50, 0, 0, 0);
        check("miss_left_addr", 32'(rom_addr), 32'd0);
        cyc(0, 0, 100, 61, 0, 0, 0);
        check("miss_below_addr", 32'(rom_addr), 32'd0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        check("miss_below_on", 32'(sprite_on), 32'd0);

        // Mirrored placement.
        cyc(0, 1, 0, 0, 100, 50, 1);
        cyc(0, 0, 100, 50, 0, 0, 0);
        check("mirror_addr_19", 32'(rom_addr), 32'd19);
        cyc(0, 0, 119, 52, 0, 0, 0);
        check("mirror_addr_40", 32'(rom_addr), 32'd40);

        // Transparency key.
        cyc(0, 1, 0, 0, 100, 50, 0);
        cyc(0, 0, 105, 50, 0, 0, 0);
        check("key_addr_5", 32'(rom_addr), 32'd5);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        check("key_sprite_on",  32'(sprite_on),  32'd0);
        check("key_sprite_rgb", 32'(sprite_rgb), 32'd0);

        // Right-edge clipping, no wrap, pos ignored without frame_start.
        cyc(0, 1, 0, 0, 1015, 50, 0);
        cyc(0, 0, 1023, 50, 0, 0, 0);
        check("edge_addr_8", 32'(rom_addr), 32'd8);
        cyc(0, 0, 0, 50, 0, 0, 0);
        check("no_wrap_addr", 32'(rom_addr), 32'd0);
        cyc(0, 0, 1023, 50, 0, 0, 0);
        check("edge_sprite_on", 32'(sprite_on), 32'd1);
        check("no_tear_addr_8", 32'(rom_addr),  32'd8);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("no_wrap_on", 32'(sprite_on), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("no_tear_on", 32'(sprite_on), 32'd1);

        // Mid-stream reset flush and restart latency.
        cyc(0, 1, 0, 0, 100, 50, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 10'(106 + i), 51, 0, 0, 0);
        cyc(1, 0, 111, 51, 0, 0, 0);
        check("flush_rom_addr",   32'(rom_addr),   32'd0);
        check("flush_sprite_on",  32'(sprite_on),  32'd0);
        check("flush_sprite_rgb", 32'(sprite_rgb), 32'd0);
        cyc(0, 0, 10, 3, 0, 0, 0);
        check("restart_addr", 32'(rom_addr), 32'd70);
        cyc(0, 0, 11, 3, 0, 0, 0);
        check("restart_on_early", 32'(sprite_on), 32'd0);
        cyc(0, 0, 12, 3, 0, 0, 0);
        check("restart_on_lat3", 32'(sprite_on),  32'd1);
        check("restart_rgb",     32'(sprite_rgb), 32'(rom[70]));
        for (int i = 0; i < 4; i++) cyc(0, 0, 10'(13 + i), 3, 0, 0, 0);

        // Randomized placements, coordinates around the sprite, rare resets.
        for (int k = 0; k < 400; k++) begin
            r_fs  = ($urandom_range(0, 39) == 0);
            r_rst = ($urandom_range(0, 149) == 0);
            r_px  = 10'(m_x0 + int'($urandom_range(0, 25)) - 3);
            r_py  = 10'(m_y0 + int'($urandom_range(0, 14)) - 2);
            cyc(r_rst, r_fs, r_px, r_py, 10'($urandom), 10'($urandom), 1'($urandom));
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
